mem_load_unit: RTL and testbench

- Parametrised load path between the MEM stage and the word-organised data memory.
- Accepts a byte-addressed load request and issues one or two word reads to memory.
- Extracts and aligns the addressed byte, halfword, word or doubleword, then zero- or sign-extends it and returns it over a valid/ready handshake.
- Next generation of the combinational read manager: XLEN is generic, memory latency is configurable, and loads that cross a word boundary are handled.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_load_unit_if.sv | 42 ++++
 rtl/load_align_extend.sv | 51 +++++
 rtl/mem_load_unit.sv | 215 +++++++++++++++++++++
 tb/tb_mem_load_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load path: access-size encodings, FSM state
// enum and the byte-offset width derivation.
// Optional feature macro used by clients: MEM_LOAD_SPLIT_EN.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_DOUBLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_FETCH1 = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // Number of byte-offset bits within one memory word.
    function automatic int unsigned off_w(input int unsigned xlen);
        return $clog2(xlen / 8);
    endfunction

    // Doubleword accesses only exist on 64-bit data paths.
    function automatic logic size_illegal(input logic [1:0] sz, input int unsigned xlen);
        return (sz == SZ_DOUBLE) && (xlen < 64);
    endfunction

endpackage

// File: rtl/mem_load_unit_if.sv
// Bundle of the load unit's request, memory and response signals.
//   slave  : the load unit (takes requests/read data, drives reads/responses)
//   master : requester + memory side
// Signals:
//   req_valid/req_ready/req_addr/req_size/req_unsigned : load request
//   mem_rd_en/mem_addr/mem_rdata                       : word-read port
//   resp_valid/resp_ready/resp_data/resp_err           : load response
interface mem_load_unit_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
);
    import mem_pkg::*;

    localparam int unsigned OFF_W   = off_w(XLEN);
    localparam int unsigned WADDR_W = ADDR_W - OFF_W;

    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_addr;
    logic [1:0]          req_size;
    logic                req_unsigned;

    logic                mem_rd_en;
    logic [WADDR_W-1:0]  mem_addr;
    logic [XLEN-1:0]     mem_rdata;

    logic                resp_valid;
    logic                resp_ready;
    logic [XLEN-1:0]     resp_data;
    logic                resp_err;

    modport slave (
        input  req_valid, req_addr, req_size, req_unsigned, mem_rdata, resp_ready,
        output req_ready, mem_rd_en, mem_addr, resp_valid, resp_data, resp_err
    );

    modport master (
        output req_valid, req_addr, req_size, req_unsigned, mem_rdata, resp_ready,
        input  req_ready, mem_rd_en, mem_addr, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/load_align_extend.sv
// Combinational extract/align/extend of a load field from a two-word window.
// Ports:
//   lo_word_i, hi_word_i : word at the access address and the following word
//   offset_i             : byte offset of the access within lo_word_i
//   size_i               : access size (mem_pkg SZ_* encoding)
//   uns_i                : 1 = zero-extend, 0 = sign-extend
//   resp_data_o          : aligned, extended field (0 on illegal size)
//   size_err_o           : size not supported for this XLEN
module load_align_extend
    import mem_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    localparam int unsigned OFF_W = off_w(XLEN)
) (
    input  logic [XLEN-1:0]  lo_word_i,
    input  logic [XLEN-1:0]  hi_word_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [1:0]       size_i,
    input  logic             uns_i,
    output logic [XLEN-1:0]  resp_data_o,
    output logic             size_err_o
);

    logic [XLEN-1:0] low_c;
    logic [XLEN-1:0] mask_c;
    logic            sign_c;
    logic            err_c;

    // Shift the window down to the addressed byte, then mask and extend.
    always_comb begin
        low_c  = XLEN'({hi_word_i, lo_word_i} >> {offset_i, 3'b000});
        mask_c = '1;
        sign_c = low_c[XLEN-1];
        case (size_i)
            SZ_BYTE: begin mask_c = XLEN'(8'hFF);         sign_c = low_c[7];  end
            SZ_HALF: begin mask_c = XLEN'(16'hFFFF);      sign_c = low_c[15]; end
            SZ_WORD: begin mask_c = XLEN'(32'hFFFF_FFFF); sign_c = low_c[31]; end
            default: ;
        endcase
        err_c = size_illegal(size_i, XLEN);
        if (err_c) begin
            resp_data_o = '0;
        end else if (uns_i || !sign_c) begin
            resp_data_o = low_c & mask_c;
        end else begin
            resp_data_o = low_c | ~mask_c;
        end
        size_err_o = err_c;
    end

endmodule

// File: rtl/mem_load_unit.sv
// Load path from the MEM stage to a word-organised data memory: accepts a
// byte-addressed load, issues one (or, for boundary-crossing loads, two)
// word reads, then returns the aligned and extended result.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_load_unit_if.slave (request, memory read, response)
// Build option MEM_LOAD_SPLIT_EN: when defined, loads crossing a word
// boundary are served with two reads; otherwise they return resp_err.
module mem_load_unit
    import mem_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_load_unit_if.slave  bus
);

    localparam int unsigned OFF_W   = off_w(XLEN);
    localparam int unsigned WADDR_W = ADDR_W - OFF_W;
    localparam int unsigned BYTES   = XLEN / 8;
    localparam int unsigned CNT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic [WADDR_W-1:0]  mem_addr_q, mem_addr_d;
`ifdef MEM_LOAD_SPLIT_EN
    logic [XLEN-1:0]     hi_q, hi_d;
    logic                cross_q, cross_d;
`endif

    logic                req_ready_q, req_ready_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic                resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]     resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;

    logic [OFF_W-1:0]    req_off_c;
    logic                req_cross_c;
    logic                req_err_c;
    logic [OFF_W-1:0]    off_sel_c;
    logic [1:0]          size_sel_c;
    logic                uns_sel_c;
    logic [XLEN-1:0]     hi_sel_c;
    logic [XLEN-1:0]     align_data_c;
    logic                size_err_c;

    // Request decode: in IDLE the aligner looks at the live request so an
    // illegal size can be rejected without a memory read.
    always_comb begin
        req_off_c   = bus.req_addr[OFF_W-1:0];
        req_cross_c = (5'(req_off_c) + (5'd1 << bus.req_size)) > 5'(BYTES);
        off_sel_c   = (state_q == ST_IDLE) ? req_off_c        : off_q;
        size_sel_c  = (state_q == ST_IDLE) ? bus.req_size     : size_q;
        uns_sel_c   = (state_q == ST_IDLE) ? bus.req_unsigned : uns_q;
`ifdef MEM_LOAD_SPLIT_EN
        hi_sel_c    = hi_d;
        req_err_c   = size_err_c;
`else
        hi_sel_c    = '0;
        req_err_c   = size_err_c | req_cross_c;
`endif
    end

    // Aligner sees next-cycle word registers so the result lands with RESP.
    load_align_extend #(.XLEN(XLEN)) u_align (
        .lo_word_i   (lo_d),
        .hi_word_i   (hi_sel_c),
        .offset_i    (off_sel_c),
        .size_i      (size_sel_c),
        .uns_i       (uns_sel_c),
        .resp_data_o (align_data_c),
        .size_err_o  (size_err_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            lo_q         <= '0;
            mem_addr_q   <= '0;
`ifdef MEM_LOAD_SPLIT_EN
            hi_q         <= '0;
            cross_q      <= 1'b0;
`endif
            req_ready_q  <= 1'b1;
            mem_rd_en_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lo_q         <= lo_d;
            mem_addr_q   <= mem_addr_d;
`ifdef MEM_LOAD_SPLIT_EN
            hi_q         <= hi_d;
            cross_q      <= cross_d;
`endif
            req_ready_q  <= req_ready_d;
            mem_rd_en_q  <= mem_rd_en_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next-state and captured-operand logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        off_d      = off_q;
        size_d     = size_q;
        uns_d      = uns_q;
        lo_d       = lo_q;
        mem_addr_d = mem_addr_q;
`ifdef MEM_LOAD_SPLIT_EN
        hi_d       = hi_q;
        cross_d    = cross_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    off_d      = req_off_c;
                    size_d     = bus.req_size;
                    uns_d      = bus.req_unsigned;
                    mem_addr_d = bus.req_addr[ADDR_W-1:OFF_W];
`ifdef MEM_LOAD_SPLIT_EN
                    cross_d    = req_cross_c;
`endif
                    state_d    = req_err_c ? ST_RESP : ST_FETCH0;
                end
            end
            ST_FETCH0: begin
                cnt_d   = CNT_W'(MEM_LATENCY - 1);
                state_d = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (cnt_q == '0) begin
                    lo_d    = bus.mem_rdata;
                    state_d = ST_RESP;
`ifdef MEM_LOAD_SPLIT_EN
                    if (cross_q) begin
                        // Second word wraps at the top of the word space.
                        mem_addr_d = mem_addr_q + WADDR_W'(1);
                        state_d    = ST_FETCH1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef MEM_LOAD_SPLIT_EN
            ST_FETCH1: begin
                cnt_d   = CNT_W'(MEM_LATENCY - 1);
                state_d = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (cnt_q == '0) begin
                    hi_d    = bus.mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register next values, decoded from the state being entered.
    always_comb begin
        req_ready_d  = (state_d == ST_IDLE);
        mem_rd_en_d  = (state_d == ST_FETCH0) || (state_d == ST_FETCH1);
        resp_valid_d = (state_d == ST_RESP);
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
            if (state_q == ST_IDLE) begin
                // Only rejected requests jump straight from IDLE to RESP.
                resp_data_d = '0;
                resp_err_d  = 1'b1;
            end else begin
                resp_data_d = align_data_c;
                resp_err_d  = 1'b0;
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Scoreboard bench for mem_load_unit (XLEN=32, one-cycle memory).
module tb_mem_load_unit;
    import mem_pkg::*;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned LAT     = 1;
    localparam int unsigned WADDR_W = ADDR_W - 2;

    typedef struct {
        logic [XLEN-1:0]    data;
        logic               err;
        int                 lat;
        int                 nrd;
        logic [WADDR_W-1:0] a0;
        logic [WADDR_W-1:0] a1;
        int                 t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   seen_valid = 1'b0;
    exp_t mon_e;
    exp_t sb[$];
    logic [WADDR_W-1:0] rd_log[$];
    logic [XLEN-1:0] mem [16];
    logic [XLEN-1:0] rd_pipe [LAT];

    mem_load_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    mem_load_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MEM_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data valid LAT cycles after the strobe, junk otherwise.
    always @(posedge clk) begin
        rd_pipe[0] <= bus.mem_rd_en ? mem[bus.mem_addr[3:0]] : 32'hDEAD_BEEF;
        for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
        if (!rst && bus.mem_rd_en) rd_log.push_back(bus.mem_addr);
    end
    assign bus.mem_rdata = rd_pipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every response cycle against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 64'(bus.resp_valid), 64'(0));
            end else begin
                mon_e = sb[0];
                if (!seen_valid) begin
                    check("latency", 64'(cyc - mon_e.t), 64'(mon_e.lat));
                    seen_valid = 1'b1;
                end
                check("resp_data", 64'(bus.resp_data), 64'(mon_e.data));
                check("resp_err", 64'(bus.resp_err), 64'(mon_e.err));
                if (bus.resp_ready) begin
                    check("num_reads", 64'(rd_log.size()), 64'(mon_e.nrd));
                    if (rd_log.size() == mon_e.nrd) begin
                        if (mon_e.nrd > 0) check("rd_addr0", 64'(rd_log[0]), 64'(mon_e.a0));
                        if (mon_e.nrd > 1) check("rd_addr1", 64'(rd_log[1]), 64'(mon_e.a1));
                    end
                    void'(sb.pop_front());
                    seen_valid = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [ADDR_W-1:0] addr, input logic [1:0] size, input logic uns,
                        input logic [XLEN-1:0] data, input logic err, input int lat, input int nrd,
                        input logic [WADDR_W-1:0] a0, input logic [WADDR_W-1:0] a1);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("req_ready_timeout", 64'(bus.req_ready), 64'(1));
            bus.req_valid = 1'b0;
            return;
        end
        rd_log.delete();
        e.data = data; e.err = err; e.lat = lat; e.nrd = nrd;
        e.a0 = a0; e.a1 = a1; e.t = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("resp_timeout", 64'(sb.size()), 64'(0));
            sb.delete();
            seen_valid = 1'b0;
        end
    endtask

    task automatic issue(input logic [ADDR_W-1:0] addr, input logic [1:0] size, input logic uns,
                         input logic [XLEN-1:0] data, input logic err, input int lat, input int nrd,
                         input logic [WADDR_W-1:0] a0, input logic [WADDR_W-1:0] a1);
        send(addr, size, uns, data, err, lat, nrd, a0, a1);
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  64'(bus.req_ready),  64'(1));
        check({tag, "_mem_rd_en"},  64'(bus.mem_rd_en),  64'(0));
        check({tag, "_mem_addr"},   64'(bus.mem_addr),   64'(0));
        check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'(0));
        check({tag, "_resp_data"},  64'(bus.resp_data),  64'(0));
        check({tag, "_resp_err"},   64'(bus.resp_err),   64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_size     = SZ_BYTE;
        bus.req_unsigned = 1'b0;
        bus.resp_ready   = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 32'h8070_F0A5;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single-word loads from 0x8070_F0A5.
        issue(32'h2, SZ_BYTE, 1'b0, 32'h0000_0070, 1'b0, 3, 1, 30'h0, 30'h0);
        issue(32'h3, SZ_BYTE, 1'b0, 32'hFFFF_FF80, 1'b0, 3, 1, 30'h0, 30'h0);
        issue(32'h0, SZ_BYTE, 1'b1, 32'h0000_00A5, 1'b0, 3, 1, 30'h0, 30'h0);
        issue(32'h1, SZ_HALF, 1'b1, 32'h0000_70F0, 1'b0, 3, 1, 30'h0, 30'h0);
        issue(32'h2, SZ_HALF, 1'b0, 32'hFFFF_8070, 1'b0, 3, 1, 30'h0, 30'h0);
        issue(32'h0, SZ_WORD, 1'b0, 32'h8070_F0A5, 1'b0, 3, 1, 30'h0, 30'h0);
        // Doubleword is illegal on a 32-bit path: no read, immediate error.
        issue(32'h0, SZ_DOUBLE, 1'b0, 32'h0, 1'b1, 1, 0, 30'h0, 30'h0);

        mem[0]  = 32'h1122_3344;
        mem[1]  = 32'hAABB_CCDD;
        mem[15] = 32'hCAFE_F00D;
        issue(32'h3, SZ_BYTE, 1'b1, 32'h0000_0011, 1'b0, 3, 1, 30'h0, 30'h0);
        issue(32'h6, SZ_HALF, 1'b0, 32'hFFFF_AABB, 1'b0, 3, 1, 30'h1, 30'h0);
`ifdef MEM_LOAD_SPLIT_EN
        issue(32'h3, SZ_WORD, 1'b0, 32'hBBCC_DD11, 1'b0, 5, 2, 30'h0, 30'h1);
        issue(32'h3, SZ_HALF, 1'b0, 32'hFFFF_DD11, 1'b0, 5, 2, 30'h0, 30'h1);
        issue(32'hFFFF_FFFF, SZ_WORD, 1'b1, 32'h2233_44CA, 1'b0, 5, 2, 30'h3FFF_FFFF, 30'h0);
        issue(32'hFFFF_FFFF, SZ_HALF, 1'b1, 32'h0000_44CA, 1'b0, 5, 2, 30'h3FFF_FFFF, 30'h0);
`else
        issue(32'h3, SZ_WORD, 1'b0, 32'h0, 1'b1, 1, 0, 30'h0, 30'h0);
        issue(32'h3, SZ_HALF, 1'b0, 32'h0, 1'b1, 1, 0, 30'h0, 30'h0);
        issue(32'hFFFF_FFFF, SZ_WORD, 1'b1, 32'h0, 1'b1, 1, 0, 30'h0, 30'h0);
`endif

        // Back-pressure: response must hold while resp_ready is low.
        bus.resp_ready = 1'b0;
        send(32'h4, SZ_WORD, 1'b1, 32'hAABB_CCDD, 1'b0, 3, 1, 30'h1, 30'h0);
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            check("stall_resp_valid", 64'(bus.resp_valid), 64'(1));
            check("stall_resp_data",  64'(bus.resp_data),  64'(32'hAABB_CCDD));
            check("stall_req_ready",  64'(bus.req_ready),  64'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_hs_req_ready",  64'(bus.req_ready),  64'(1));
        check("post_hs_resp_valid", 64'(bus.resp_valid), 64'(0));
        wait_done();

        // Reset while a load is outstanding; it must be dropped.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_size  = SZ_WORD;
`ifdef MEM_LOAD_SPLIT_EN
        bus.req_addr  = 32'h3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
`else
        bus.req_addr  = 32'h4;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (1) @(negedge clk);
`endif
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;

        issue(32'h0, SZ_WORD, 1'b1, 32'h1122_3344, 1'b0, 3, 1, 30'h0, 30'h0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
